// File: rtl/pulse_pkg.sv
// Types and defaults shared by the pulse stretcher (write side) and the
// pulse catcher (read side) of the cross-domain pulse handshake.
package pulse_pkg;

   // 2'd3 is unused; the catcher treats it as an illegal state and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int MIN_WIDTH_DEF   = 1;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; the output is the
// last stage of the chain and everything resets to 0.
module bit_sync
   import pulse_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   // NOTE: sequential state is always updated with non-blocking assignments so every
   // flop samples the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_catcher.sv
// Read-side catcher: synchronizes a stretched level, rejects short glitches,
// emits one strobe per accepted pulse, measures its width and drives the ack level.
module pulse_catcher
   import pulse_pkg::*;
#(
   parameter int N           = 32,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int MIN_WIDTH   = MIN_WIDTH_DEF,
   parameter int GW          = 8
) (
   input  logic          rd_clk,
   input  logic          rd_resetn,
   input  logic          pulse_in,
   output logic          pulse_out,
   output logic          ack,
   output logic [N-1:0]  pulse_width,
   output logic          width_valid,
   output logic          width_sat,
   output logic [N-1:0]  pulse_count,
   output logic [GW-1:0] glitch_count
);

   localparam logic [N-1:0]  ONE        = N'(1);
   localparam logic [N-1:0]  CNT_MAX    = '1;
   localparam logic [N-1:0]  MIN_W      = N'(MIN_WIDTH);
   localparam logic [GW-1:0] GLITCH_ONE = GW'(1);
   localparam logic [GW-1:0] GLITCH_MAX = '1;

   logic         sig;
   state_t       state;
   logic [N-1:0] cnt;
   logic [N-1:0] cnt_inc;
   logic         sat;
   logic         accept;

   bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (rd_clk),
      .rst_n (rd_resetn),
      .d     (pulse_in),
      .q     (sig)
   );

   assign cnt_inc = cnt + ONE;

   // accept marks the edge on which the synchronized level has been high MIN_WIDTH cycles.
   // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
   always_comb begin
      accept = 1'b0;
      if (sig) begin
         if (state == IDLE) begin
            accept = (MIN_WIDTH == 1);
         end else if (state == QUAL) begin
            accept = (cnt_inc == MIN_W);
         end
      end
   end

   always_ff @(posedge rd_clk or negedge rd_resetn) begin
      if (!rd_resetn) begin
         state        <= IDLE;
         cnt          <= '0;
         sat          <= 1'b0;
         pulse_out    <= 1'b0;
         ack          <= 1'b0;
         pulse_width  <= '0;
         width_valid  <= 1'b0;
         width_sat    <= 1'b0;
         pulse_count  <= '0;
         glitch_count <= '0;
      end else begin
         pulse_out   <= 1'b0;
         width_valid <= 1'b0;

         if (accept) begin
            pulse_out   <= 1'b1;
            ack         <= 1'b1;
            pulse_count <= pulse_count + ONE;
         end

         case (state)
            IDLE: begin
               if (sig) begin
                  cnt   <= ONE;
                  state <= accept ? HOLD : QUAL;
               end
            end
            QUAL: begin
               if (sig) begin
                  cnt <= cnt_inc;
                  if (accept) state <= HOLD;
               end else begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (glitch_count != GLITCH_MAX) glitch_count <= glitch_count + GLITCH_ONE;
               end
            end
            HOLD: begin
               if (sig) begin
                  // Width saturates rather than wraps; sat records that a cycle was lost.
                  if (cnt == CNT_MAX) sat <= 1'b1;
                  else                cnt <= cnt_inc;
               end else begin
                  width_valid <= 1'b1;
                  pulse_width <= cnt;
                  width_sat   <= sat;
                  ack         <= 1'b0;
                  cnt         <= '0;
                  sat         <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               cnt   <= '0;
               sat   <= 1'b0;
               ack   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pulse_catcher.md
Name: pulse_catcher

Overview:
- Receive-side partner of the pulse stretcher. Lives entirely in the read clock domain.
- Synchronizes a stretched level arriving from another clock domain, filters glitches and emits exactly one single-cycle pulse per accepted stretched pulse.
- Measures the stretched width in rd_clk cycles and returns a level ack, so the sender can run a 4-phase handshake.
- Keeps running counts of accepted pulses and rejected glitches.

Parameters:
- N, 32: width of pulse_count and pulse_width.
- SYNC_STAGES, 2: synchronizer flops on pulse_in. Legal range ≥2.
- MIN_WIDTH, 1: synchronized high cycles needed to accept a pulse. Legal range 1..2^N-1.
- GW, 8: width of glitch_count.

Ports:
- rd_clk  in  1  sole clock.
- rd_resetn  in  1  asynchronous, active-low reset.
- pulse_in  in  1  asynchronous stretched level from the write domain.
- pulse_out  out  1  one-cycle strobe per accepted pulse.
- ack  out  1  level; high from acceptance until the synchronized input falls.
- pulse_width  out  N  synchronized high duration of the last accepted pulse, in cycles.
- width_valid  out  1  one-cycle strobe; pulse_width is updated in the same cycle.
- width_sat  out  1  width counter saturated. Updated with width_valid.
- pulse_count  out  N  accepted pulses, wraps modulo 2^N.
- glitch_count  out  GW  rejected pulses, saturates at 2^GW-1.

Behaviour:
- Reset:
  - All outputs are 0, sync chain is 0, state is IDLE, internal counter cnt is 0.
  - Reset asserted mid-operation clears everything immediately, including dropping ack.
  - If pulse_in is still high at reset release, it is treated as a fresh pulse.
- Sync:
  - sig is the last stage of a SYNC_STAGES flop chain.
  - If pulse_in is stable high before edge 1, sig is high after edge SYNC_STAGES.
- FSM, all outputs registered:
  - IDLE:
    - sig=1 and MIN_WIDTH=1: cnt=1, go to HOLD, pulse_out=1, ack=1, pulse_count+1.
    - sig=1 and MIN_WIDTH>1: cnt=1, go to QUAL.
  - QUAL:
    - sig=1: cnt+1. If the new cnt equals MIN_WIDTH: go to HOLD, pulse_out=1, ack=1, pulse_count+1.
    - sig=0: glitch_count+1 (saturating), go to IDLE. No pulse_out, no width_valid.
  - HOLD:
    - sig=1: cnt+1, saturating at 2^N-1; set internal sat flag on saturation.
    - sig=0: width_valid=1, pulse_width=cnt, width_sat=sat flag, ack=0, go to IDLE, clear cnt and sat flag.
- Latency: with pulse_in stable high before edge 1, pulse_out is high in the cycle after edge SYNC_STAGES+MIN_WIDTH.
- Width rule: if sig is high for exactly W cycles (W ≥ MIN_WIDTH), then pulse_width = min(W, 2^N-1).
- width_valid arrives one edge after sig falls.
- Strobes: pulse_out and width_valid are never high for more than one cycle. They are never high in the same cycle.
- Back-to-back: a single low cycle on sig is sufficient. IDLE accepts a new rise on the edge after width_valid.
- Between width_valid strobes, pulse_width and width_sat hold their last values.
- pulse_count wraps from 2^N-1 to 0 without a flag.
- ack never rises before pulse_out and falls only on the width_valid edge or on reset.

Decomposition:
- Shared package pulse_pkg:
  - state enum: IDLE=2'd0, QUAL=2'd1, HOLD=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
  - default constants SYNC_STAGES_DEF=2 and MIN_WIDTH_DEF=1, shared with the stretcher.
- One sub-module, bit_sync: parameterized SYNC_STAGES chain with async active-low reset to 0. Reusable by the stretcher.
- FSM, counters and output registers stay in pulse_catcher.

Test Plan (N=16, SYNC_STAGES=2, MIN_WIDTH=3, GW=8, rd_clk 70 ns unless stated):
- Reset: hold rd_resetn=0 with pulse_in toggling -> all outputs 0. After release with pulse_in=0, outputs stay 0 for 20 cycles.
- Nominal: pulse_in high for exactly 7 rd_clk cycles, synchronous to rd_clk, from before edge 1 ->
  - pulse_out single cycle after edge 5;
  - ack high from edge 5 to edge 10;
  - width_valid at edge 10 with pulse_width=7, width_sat=0;
  - pulse_count=1.
- Glitch: pulse_in high for 2 cycles -> no pulse_out, no width_valid, ack stays 0, glitch_count=1, pulse_count unchanged.
- Saturation, separate instance with N=4: pulse_in high for 20 cycles -> width_valid with pulse_width=15 and width_sat=1. The next 5-cycle pulse reports pulse_width=5 and width_sat=0.
- Back-to-back: 4 high, 1 low, 5 high cycles -> two pulse_out strobes, widths 4 then 5, pulse_count=2, glitch_count=0.
- Reset mid-HOLD: assert rd_resetn=0 while ack=1 and pulse_in is held high ->
  - ack, pulse_count and pulse_width drop to 0 asynchronously;
  - after release, a new pulse_out appears after edge 5.
- Cross-domain: pulse_in driven by the stretcher on a 10 ns wr_clk; single wr_clk input pulse -> exactly one pulse_out, and pulse_count matches the stretcher's count output.
